fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Multi-cycle Y86-64 fetch controller between a byte-wide instruction memory and the decode stage.
- From the current PC it reads byte 0, classifies the icode, then fetches the register byte and the 8-byte valC only when the instruction needs them.
- It presents the assembled instruction to decode with a valid/ready handshake.
- It tracks the PC, accepts redirects, and stops on halt, invalid instruction or memory error.

Parameters:
- ADDR_W, 64, PC / memory address width.
- RESET_PC, 0, PC loaded on reset.
- TIMEOUT_CYCLES, 16, watchdog limit in cycles; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- pc_load  in  1  redirect strobe.
- pc_in  in  ADDR_W  redirect target.
- imem_req  out  1  read request; held high until imem_rvalid.
- imem_addr  out  ADDR_W  byte address; stable while imem_req is high.
- imem_rvalid  in  1  response valid; only meaningful while imem_req is high.
- imem_rdata  in  8  response byte.
- imem_rerr  in  1  response error; qualified by imem_rvalid.
- out_valid  out  1  fetched instruction available.
- out_ready  in  1  decode accepts.
- icode  out  4  instruction code.
- ifun  out  4  function code.
- rA  out  4  register A; 4'hF when the instruction has no register byte.
- rB  out  4  register B; 4'hF when the instruction has no register byte.
- valC  out  64  constant; 0 when the instruction has no valC.
- valP  out  ADDR_W  address of the next sequential instruction.
- stat  out  2  0=AOK, 1=HLT, 2=ADR, 3=INS.
- busy  out  1  state is not IDLE or STOPPED.

Behaviour:
- Reset: state FETCH0, pc=RESET_PC, all outputs 0 except rA=rB=4'hF.
  - Fetching starts on the first clock after rst_n deasserts.
- Decode rules for byte 0 (bits [7:4]=icode, [3:0]=ifun):
  - need_regids for icode 2,3,4,5,6,A,B.
  - need_valC for icode 3,4,5,7,8.
  - icode >B is invalid.
  - Instruction length = 1 + need_regids + 8*need_valC.
- States and transitions:
  - FETCH0: addr=pc. On rvalid:
    - rerr → OUT with stat=ADR.
    - invalid icode → OUT with stat=INS.
    - need_regids → REGS.
    - else need_valC → VALC.
    - else → OUT (stat=HLT for icode 0, otherwise AOK).
  - REGS: addr=pc+1; latch rA=rdata[7:4], rB=rdata[3:0]. On rvalid go to VALC or OUT.
  - VALC: 3-bit byte counter k=0..7; addr=pc+1+need_regids+k. Each byte goes to valC[8k+7:8k] (little-endian). After k=7 → OUT.
  - OUT: out_valid=1; all fields held stable until out_ready.
    - On the handshake with stat AOK: pc←valP, go to FETCH0.
    - On the handshake with any other stat → STOPPED.
  - STOPPED: no requests; fields keep their last values; out_valid=0.
- Errors and wrap-around:
  - An rerr in REGS or VALC ends the fetch immediately with stat=ADR.
  - Address arithmetic wraps modulo 2^ADDR_W.
- Latency: a fetch with no wait states takes 1/2/9/10 cycles from FETCH0 entry to out_valid, plus the memory wait cycles.
- Redirect:
  - pc_load in any state, including OUT and STOPPED, has priority over everything.
  - Next cycle: pc=pc_in, state FETCH0, out_valid=0, imem_req drops for that cycle, and any in-flight response is discarded.
  - The memory must treat a dropped imem_req as a cancel.
  - pc_load in the same cycle as an OUT handshake: the handshake completes, and pc_in wins over valP.
- Reset mid-fetch aborts immediately, returns to the reset values, and drops imem_req asynchronously.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- With the macro: a counter counts cycles with imem_req=1 and imem_rvalid=0. Reaching TIMEOUT_CYCLES ends the fetch with stat=ADR, exactly like rerr. The counter clears on every rvalid and on every redirect.
- Without the macro: no counter logic, and the block waits forever for rvalid.

Decomposition:
- Shared package y86_pkg:
  - icode constants (I_HALT … I_POPQ).
  - stat encoding (STAT_AOK/HLT/ADR/INS).
  - REG_NONE=4'hF.
  - A length function returning 1/2/9/10.
- One natural sub-module: icode_classifier. It is combinational: icode in, need_regids/need_valC/instr_valid out, and is reusable by other stages.
- The FSM, byte counter, PC register and watchdog stay in fetch_sequencer.

Test Plan:
- Bytes at 0: 30 F3 08 00 00 00 00 00 00 00 (irmovq $8,%rbx), rvalid same cycle → 10 requests at addr 0..9; out icode=3, rA=F, rB=3, valC=8, valP=10, stat=AOK.
- Sequence 10 60 12 00 (nop, addq, halt), out_ready always 1 → three outputs with valP=1,3,4; stat AOK, AOK, HLT; then STOPPED with imem_req=0.
- Byte 0=C0 → single request, out stat=INS, valP=1, then STOPPED. pc_load to 0x20 then recovers and fetches from 0x20.
- irmovq with rerr on byte 5 (addr 5) → out stat=ADR right after that byte, no request to addr 6.
- pc_load=1, pc_in=0x40 during VALC k=3 → next cycle imem_req=0, then FETCH0 at 0x40; the stale response is ignored.
- out_ready=0 for 5 cycles in OUT → fields stable, no new requests. With FETCH_TIMEOUT_EN and rvalid never asserted → stat=ADR after 16 cycles.

Source files
------------

// File: rtl/y86_pkg.sv
`default_nettype none
// =============================================================================
// Package  : y86_pkg
// Brief    : Y86-64 icode constants, status encoding, fetch states and the
//            instruction length helper shared by the front-end stages.
// Revision : 1.0
// =============================================================================
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] REG_NONE = 4'hF;

   typedef enum logic [1:0] {
      STAT_AOK = 2'd0,
      STAT_HLT = 2'd1,
      STAT_ADR = 2'd2,
      STAT_INS = 2'd3
   } stat_e;

   typedef enum logic [2:0] {
      S_FETCH0  = 3'd0,
      S_REGS    = 3'd1,
      S_VALC    = 3'd2,
      S_OUT     = 3'd3,
      S_STOPPED = 3'd4
   } fetch_state_e;

   // Length in bytes: opcode, optional register byte, optional 8-byte constant.
   function automatic logic [3:0] instr_len(input logic need_regids, input logic need_valc);
      return 4'd1 + {3'd0, need_regids} + (need_valc ? 4'd8 : 4'd0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/icode_classifier.sv
`default_nettype none
// =============================================================================
// Module   : icode_classifier
// Brief    : Combinational Y86-64 icode decode: which trailing fields follow
//            the opcode byte and whether the icode exists at all.
// Revision : 1.0
// =============================================================================
module icode_classifier
   import y86_pkg::*;
(
   input  logic [3:0] icode,
   output logic       need_regids,
   output logic       need_valC,
   output logic       instr_valid
);

   always_comb begin
      need_regids = icode inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
                                  I_OPQ, I_PUSHQ, I_POPQ};
      need_valC   = icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL};
      instr_valid = (icode <= I_POPQ);
   end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : fetch_sequencer
// Brief    : Multi-cycle Y86-64 fetch controller between a byte-wide
//            instruction memory and decode (valid/ready output).
// Options  : FETCH_TIMEOUT_EN adds a response watchdog (TIMEOUT_CYCLES).
// Revision : 1.0
// =============================================================================
module fetch_sequencer
   import y86_pkg::*;
#(
   parameter int unsigned       ADDR_W         = 64,
   parameter logic [ADDR_W-1:0] RESET_PC       = '0,
   parameter int unsigned       TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_in,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rvalid,
   input  logic [7:0]        imem_rdata,
   input  logic              imem_rerr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        icode,
   output logic [3:0]        ifun,
   output logic [3:0]        rA,
   output logic [3:0]        rB,
   output logic [63:0]       valC,
   output logic [ADDR_W-1:0] valP,
   output logic [1:0]        stat,
   output logic              busy
);

   if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   fetch_state_e      r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_pc, r_valp, w_addr;
   logic [3:0]        r_icode, r_ifun, r_ra, r_rb;
   logic [63:0]       r_valc;
   stat_e             r_stat;
   logic              r_need_regids, r_need_valc;
   logic [2:0]        r_k;
   logic              r_active, r_started;
   logic              w_req, w_rsp, w_err, w_timeout;
   logic              w_cls_regids, w_cls_valc, w_cls_valid;

   icode_classifier u_classifier (
      .icode       (imem_rdata[7:4]),
      .need_regids (w_cls_regids),
      .need_valC   (w_cls_valc),
      .instr_valid (w_cls_valid)
   );

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned c_wd_w = $clog2(TIMEOUT_CYCLES + 1);
   logic [c_wd_w-1:0] r_wd;

   assign w_timeout = w_req && !imem_rvalid && (r_wd == c_wd_w'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_wd <= '0;
      else if (pc_load || (w_req && imem_rvalid) || w_timeout)
         r_wd <= '0;
      else if (w_req)
         r_wd <= r_wd + 1'b1;
   end
`else
   assign w_timeout = 1'b0;
`endif

   // r_active is low for one cycle after reset or redirect, which cancels the request.
   always_comb begin
      w_req  = r_active && (r_state inside {S_FETCH0, S_REGS, S_VALC});
      w_addr = r_pc;
      case (r_state)
         S_REGS:  w_addr = r_pc + ADDR_W'(1);
         S_VALC:  w_addr = r_pc + ADDR_W'(1) + ADDR_W'(r_need_regids) + ADDR_W'(r_k);
         default: w_addr = r_pc;
      endcase
      w_rsp = w_req && imem_rvalid;
      w_err = (w_rsp && imem_rerr) || w_timeout;

      w_state_nxt = r_state;
      case (r_state)
         S_FETCH0: begin
            if (w_err || (w_rsp && !w_cls_valid))  w_state_nxt = S_OUT;
            else if (w_rsp && w_cls_regids)        w_state_nxt = S_REGS;
            else if (w_rsp && w_cls_valc)          w_state_nxt = S_VALC;
            else if (w_rsp)                        w_state_nxt = S_OUT;
         end
         S_REGS: begin
            if (w_err)      w_state_nxt = S_OUT;
            else if (w_rsp) w_state_nxt = r_need_valc ? S_VALC : S_OUT;
         end
         S_VALC: begin
            if (w_err || (w_rsp && r_k == 3'd7)) w_state_nxt = S_OUT;
         end
         S_OUT: begin
            if (out_ready) w_state_nxt = (r_stat == STAT_AOK) ? S_FETCH0 : S_STOPPED;
         end
         default: w_state_nxt = r_state;
      endcase
      if (pc_load) w_state_nxt = S_FETCH0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_FETCH0;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc          <= RESET_PC;
         r_valp        <= '0;
         r_icode       <= '0;
         r_ifun        <= '0;
         r_ra          <= REG_NONE;
         r_rb          <= REG_NONE;
         r_valc        <= '0;
         r_stat        <= STAT_AOK;
         r_need_regids <= 1'b0;
         r_need_valc   <= 1'b0;
         r_k           <= '0;
         r_active      <= 1'b0;
         r_started     <= 1'b0;
      end else if (pc_load) begin
         r_pc      <= pc_in;
         r_k       <= '0;
         r_active  <= 1'b0;
         r_started <= 1'b1;
      end else begin
         r_active  <= 1'b1;
         r_started <= 1'b1;
         case (r_state)
            S_FETCH0: begin
               if (w_err) begin
                  r_icode <= '0;
                  r_ifun  <= '0;
                  r_ra    <= REG_NONE;
                  r_rb    <= REG_NONE;
                  r_valc  <= '0;
                  r_valp  <= r_pc;
                  r_stat  <= STAT_ADR;
               end else if (w_rsp) begin
                  r_icode       <= imem_rdata[7:4];
                  r_ifun        <= imem_rdata[3:0];
                  r_ra          <= REG_NONE;
                  r_rb          <= REG_NONE;
                  r_valc        <= '0;
                  r_valp        <= r_pc + ADDR_W'(instr_len(w_cls_regids, w_cls_valc));
                  r_need_regids <= w_cls_regids;
                  r_need_valc   <= w_cls_valc;
                  r_k           <= '0;
                  if (!w_cls_valid)                 r_stat <= STAT_INS;
                  else if (imem_rdata[7:4] == I_HALT) r_stat <= STAT_HLT;
                  else                              r_stat <= STAT_AOK;
               end
            end
            S_REGS: begin
               if (w_err) r_stat <= STAT_ADR;
               else if (w_rsp) begin
                  r_ra <= imem_rdata[7:4];
                  r_rb <= imem_rdata[3:0];
               end
            end
            S_VALC: begin
               if (w_err) r_stat <= STAT_ADR;
               else if (w_rsp) begin
                  r_valc[{r_k, 3'b000} +: 8] <= imem_rdata;
                  r_k                        <= r_k + 3'd1;
               end
            end
            S_OUT: begin
               if (out_ready && r_stat == STAT_AOK) r_pc <= r_valp;
            end
            default: ;
         endcase
      end
   end

   assign imem_req  = w_req;
   assign imem_addr = w_addr;
   assign out_valid = (r_state == S_OUT);
   assign busy      = r_started && (r_state != S_STOPPED);
   assign icode     = r_icode;
   assign ifun      = r_ifun;
   assign rA        = r_ra;
   assign rB        = r_rb;
   assign valC      = r_valc;
   assign valP      = r_valp;
   assign stat      = r_stat;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Self-checking bench for fetch_sequencer: directed scenarios plus
//            random programs checked against a byte-level Y86 fetch model.
// Revision : 1.0
// =============================================================================
module tb_fetch_sequencer;

   typedef struct packed {
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [63:0] valc;
      logic [63:0] valp;
      logic [1:0]  stat;
      int          nreq;
   } instr_t;

   logic        clk = 1'b0;
   logic        rst_n, pc_load, imem_req, imem_rvalid, imem_rerr;
   logic        out_valid, out_ready, busy;
   logic [63:0] pc_in, imem_addr, valC, valP;
   logic [7:0]  imem_rdata;
   logic [3:0]  icode, ifun, rA, rB;
   logic [1:0]  stat;

   logic [7:0]  mem [256];
   bit          err_m [256];
   int          lat_pct, rdy_pct;
   logic [63:0] req_q [$];
   instr_t      out_q [$];
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(.ADDR_W(64), .RESET_PC(64'd0), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .pc_load(pc_load), .pc_in(pc_in),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .imem_rerr(imem_rerr), .out_valid(out_valid),
      .out_ready(out_ready), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
      .valC(valC), .valP(valP), .stat(stat), .busy(busy)
   );

   // Walks the memory image byte by byte following the Y86 encoding rules.
   function automatic instr_t model(input logic [63:0] pc);
      instr_t      m;
      logic [7:0]  b;
      logic [63:0] a;
      bit          regs, vc;
      m = '{icode: 4'h0, ifun: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'd0,
            valp: pc, stat: 2'd2, nreq: 1};
      if (err_m[pc[7:0]]) return m;
      b       = mem[pc[7:0]];
      m.icode = b[7:4];
      m.ifun  = b[3:0];
      regs    = m.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
      vc      = m.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
      m.valp  = pc + 64'd1 + (regs ? 64'd1 : 64'd0) + (vc ? 64'd8 : 64'd0);
      if (m.icode > 4'hB) begin
         m.stat = 2'd3;
         return m;
      end
      if (regs) begin
         a = pc + 64'd1;
         m.nreq++;
         if (err_m[a[7:0]]) return m;
         b    = mem[a[7:0]];
         m.ra = b[7:4];
         m.rb = b[3:0];
      end
      if (vc) begin
         for (int k = 0; k < 8; k++) begin
            a = pc + 64'd1 + (regs ? 64'd1 : 64'd0) + 64'(k);
            m.nreq++;
            if (err_m[a[7:0]]) return m;
            m.valc[8*k +: 8] = mem[a[7:0]];
         end
      end
      m.stat = (m.icode == 4'h0) ? 2'd1 : 2'd0;
      return m;
   endfunction

   // One cycle: memory responds to the current request, decode decides ready.
   task automatic step();
      instr_t o;
      imem_rvalid = 1'b0;
      imem_rerr   = 1'b0;
      imem_rdata  = 8'($urandom);
      if (imem_req === 1'b1 && $urandom_range(99) >= lat_pct) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem[imem_addr[7:0]];
         imem_rerr   = err_m[imem_addr[7:0]];
         req_q.push_back(imem_addr);
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      if (out_valid === 1'b1 && out_ready) begin
         o = '{icode: icode, ifun: ifun, ra: rA, rb: rB, valc: valC,
               valp: valP, stat: stat, nreq: 0};
         out_q.push_back(o);
      end
      @(negedge clk);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin
         mem[i]   = 8'h00;
         err_m[i] = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; pc_load = 1'b0; pc_in = '0; imem_rvalid = 1'b0;
      imem_rerr = 1'b0; imem_rdata = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      req_q.delete();
      out_q.delete();
   endtask

   task automatic run_until_stop(input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (busy === 1'b0) begin
            done = 1'b1;
            break;
         end
      end
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL run_budget: busy=%b after %0d cycles, required 0", busy, budget);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pc_load = 1'b0; pc_in = '0; imem_rvalid = 1'b0;
      imem_rerr = 1'b0; imem_rdata = '0; out_ready = 1'b0;
      clear_mem();
      #12;
      tests++;
      if ({imem_req, out_valid, busy, icode, ifun, rA, rB, valC, valP, stat} !==
          {3'b000, 8'h00, 8'hFF, 64'd0, 64'd0, 2'd0}) begin
         fails++;
         $display("FAIL reset_state: req=%b valid=%b busy=%b rA=%h rB=%h valC=%h valP=%h stat=%0d, required 0/0/0 F F 0 0 0",
                  imem_req, out_valid, busy, rA, rB, valC, valP, stat);
      end
      @(negedge clk);
      rst_n = 1'b1;
      lat_pct = 100; rdy_pct = 0;
      step();
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== 64'd0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL first_req: req=%b addr=%h busy=%b, required 1 0 1", imem_req, imem_addr, busy);
      end
      step(); step();
      #3 rst_n = 1'b0;
      #1;
      tests++;
      if (imem_req !== 1'b0 || busy !== 1'b0 || rA !== 4'hF) begin
         fails++;
         $display("FAIL reset_async: req=%b busy=%b rA=%h, required 0 0 F", imem_req, busy, rA);
      end
      @(negedge clk);
   endtask

   task automatic test_irmovq();
      int cyc = 0;
      logic [7:0] prog [10] = '{8'h30, 8'hF3, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      int bad = 0;
      clear_mem();
      for (int i = 0; i < 10; i++) mem[i] = prog[i];
      lat_pct = 0; rdy_pct = 100;
      do_reset();
      while (out_valid !== 1'b1 && cyc < 60) begin
         if (imem_req === 1'b1) cyc++;
         step();
      end
      tests++;
      if (cyc != 10) begin
         fails++;
         $display("FAIL irmovq_latency: %0d request cycles, required 10", cyc);
      end
      tests++;
      if ({icode, ifun, rA, rB, valC, valP, stat} !== {4'h3, 4'h0, 4'hF, 4'h3, 64'd8, 64'd10, 2'd0}) begin
         fails++;
         $display("FAIL irmovq_fields: icode=%h rA=%h rB=%h valC=%h valP=%h stat=%0d, required 3 F 3 8 a 0",
                  icode, rA, rB, valC, valP, stat);
      end
      foreach (req_q[i]) if (req_q[i] !== 64'(i)) bad++;
      tests++;
      if (bad != 0 || req_q.size() != 10) begin
         fails++;
         $display("FAIL irmovq_addrs: %0d requests, %0d out of order, required 10 at 0..9", req_q.size(), bad);
      end
   endtask

   task automatic test_sequence();
      clear_mem();
      mem[0] = 8'h10; mem[1] = 8'h60; mem[2] = 8'h12; mem[3] = 8'h00;
      lat_pct = 0; rdy_pct = 100;
      do_reset();
      run_until_stop(100);
      tests++;
      if (out_q.size() != 3) begin
         fails++;
         $display("FAIL seq_count: %0d outputs, required 3", out_q.size());
      end else begin
         tests++;
         if ({out_q[0].valp, out_q[1].valp, out_q[2].valp, out_q[0].stat, out_q[1].stat, out_q[2].stat} !==
             {64'd1, 64'd3, 64'd4, 2'd0, 2'd0, 2'd1}) begin
            fails++;
            $display("FAIL seq_valp_stat: valP %0d %0d %0d stat %0d %0d %0d, required 1 3 4 / 0 0 1",
                     out_q[0].valp, out_q[1].valp, out_q[2].valp, out_q[0].stat, out_q[1].stat, out_q[2].stat);
         end
         tests++;
         if ({out_q[1].icode, out_q[1].ra, out_q[1].rb} !== {4'h6, 4'h1, 4'h2}) begin
            fails++;
            $display("FAIL seq_addq: icode=%h rA=%h rB=%h, required 6 1 2", out_q[1].icode, out_q[1].ra, out_q[1].rb);
         end
      end
      req_q.delete();
      repeat (4) step();
      tests++;
      if (imem_req !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || req_q.size() != 0) begin
         fails++;
         $display("FAIL seq_stopped: req=%b valid=%b busy=%b reqs=%0d, required 0 0 0 0",
                  imem_req, out_valid, busy, req_q.size());
      end
   endtask

   task automatic test_invalid();
      clear_mem();
      mem[0] = 8'hC0; mem[8'h20] = 8'h10; mem[8'h21] = 8'h00;
      lat_pct = 0; rdy_pct = 100;
      do_reset();
      run_until_stop(50);
      tests++;
      if (out_q.size() != 1 || req_q.size() != 1 || out_q[0].stat !== 2'd3 || out_q[0].valp !== 64'd1) begin
         fails++;
         $display("FAIL invalid_ins: outputs=%0d reqs=%0d stat=%0d valP=%h, required 1 1 3 1",
                  out_q.size(), req_q.size(), (out_q.size() > 0) ? out_q[0].stat : 2'bx,
                  (out_q.size() > 0) ? out_q[0].valp : 64'hx);
      end
      pc_load = 1'b1; pc_in = 64'h20;
      step();
      pc_load = 1'b0;
      out_q.delete(); req_q.delete();
      run_until_stop(50);
      tests++;
      if (out_q.size() != 2 || req_q.size() != 2 || req_q[0] !== 64'h20 ||
          {out_q[0].valp, out_q[0].stat, out_q[1].valp, out_q[1].stat} !== {64'h21, 2'd0, 64'h22, 2'd1}) begin
         fails++;
         $display("FAIL invalid_recover: outputs=%0d reqs=%0d, required 2 outputs (21/AOK, 22/HLT) from 0x20",
                  out_q.size(), req_q.size());
      end
   endtask

   task automatic test_rerr();
      clear_mem();
      mem[0] = 8'h30; mem[1] = 8'hF3; mem[2] = 8'h08;
      err_m[5] = 1'b1;
      lat_pct = 0; rdy_pct = 100;
      do_reset();
      run_until_stop(50);
      tests++;
      if (out_q.size() != 1 || req_q.size() != 6 || req_q[req_q.size()-1] !== 64'd5 ||
          {out_q[0].icode, out_q[0].rb, out_q[0].valc, out_q[0].stat} !== {4'h3, 4'h3, 64'd8, 2'd2}) begin
         fails++;
         $display("FAIL rerr_valc: outputs=%0d reqs=%0d, required 1 output stat ADR valC 8 after 6 requests ending at 5",
                  out_q.size(), req_q.size());
      end
   endtask

   task automatic test_redirect();
      int i = 0;
      clear_mem();
      mem[0] = 8'h30; mem[1] = 8'hF3; mem[8'h40] = 8'h10; mem[8'h41] = 8'h00;
      lat_pct = 0; rdy_pct = 100;
      do_reset();
      while (!(imem_req === 1'b1 && imem_addr === 64'd5) && i < 40) begin
         step();
         i++;
      end
      pc_load = 1'b1; pc_in = 64'h40;
      step();
      pc_load = 1'b0;
      tests++;
      if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL redirect_drop: req=%b valid=%b, required 0 0", imem_req, out_valid);
      end
      imem_rvalid = 1'b1; imem_rdata = 8'hFF; imem_rerr = 1'b1;
      @(negedge clk);
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h40) begin
         fails++;
         $display("FAIL redirect_target: req=%b addr=%h, required 1 40", imem_req, imem_addr);
      end
      out_q.delete(); req_q.delete();
      run_until_stop(50);
      tests++;
      if (out_q.size() != 2 || req_q.size() != 2 ||
          {out_q[0].valp, out_q[0].stat, out_q[1].valp, out_q[1].stat} !== {64'h41, 2'd0, 64'h42, 2'd1}) begin
         fails++;
         $display("FAIL redirect_run: outputs=%0d reqs=%0d, required 2 outputs (41/AOK, 42/HLT)",
                  out_q.size(), req_q.size());
      end
   endtask

   task automatic test_stall();
      instr_t held;
      int     i = 0;
      clear_mem();
      mem[0] = 8'h20; mem[1] = 8'h45; mem[2] = 8'h00;
      lat_pct = 0; rdy_pct = 0;
      do_reset();
      while (out_valid !== 1'b1 && i < 20) begin
         step();
         i++;
      end
      held = '{icode: icode, ifun: ifun, ra: rA, rb: rB, valc: valC, valp: valP, stat: stat, nreq: 0};
      for (int c = 0; c < 5; c++) begin
         step();
         tests++;
         if (out_valid !== 1'b1 || imem_req !== 1'b0 ||
             {icode, ifun, rA, rB, valC, valP, stat} !== {4'h2, 4'h0, 4'h4, 4'h5, 64'd0, 64'd2, 2'd0}) begin
            fails++;
            $display("FAIL stall_hold: cycle %0d valid=%b req=%b rA=%h rB=%h valP=%h, required 1 0 4 5 2 (held rA %h)",
                     c, out_valid, imem_req, rA, rB, valP, held.ra);
         end
      end
      rdy_pct = 100;
      run_until_stop(50);
      tests++;
      if (out_q.size() != 2 || out_q[1].stat !== 2'd1) begin
         fails++;
         $display("FAIL stall_release: outputs=%0d, required 2 ending in HLT", out_q.size());
      end
   endtask

   task automatic test_timeout();
      int cyc = 0;
      clear_mem();
      lat_pct = 100; rdy_pct = 0;
      do_reset();
`ifdef FETCH_TIMEOUT_EN
      while (out_valid !== 1'b1 && cyc < 60) begin
         if (imem_req === 1'b1) cyc++;
         step();
      end
      tests++;
      if (cyc != 16 || stat !== 2'd2 || out_valid !== 1'b1) begin
         fails++;
         $display("FAIL timeout_adr: %0d waiting cycles valid=%b stat=%0d, required 16 1 2", cyc, out_valid, stat);
      end
`else
      step();
      for (int c = 0; c < 40; c++) begin
         if (imem_req !== 1'b1 || out_valid !== 1'b0) cyc++;
         step();
      end
      tests++;
      if (cyc != 0) begin
         fails++;
         $display("FAIL wait_forever: %0d cycles without a pending request, required 0", cyc);
      end
`endif
   endtask

   task automatic test_random();
      instr_t      exp_q [$];
      logic [63:0] exp_req [$];
      instr_t      m;
      logic [63:0] p;
      int          pc, len, ic, bad;
      for (int it = 0; it < 20; it++) begin
         for (int i = 0; i < 256; i++) begin
            mem[i]   = 8'($urandom);
            err_m[i] = 1'b0;
         end
         pc = 0;
         while (pc < 200) begin
            ic      = $urandom_range(1, 11);
            mem[pc] = {4'(ic), 4'($urandom)};
            len     = 1 + ((ic inside {2, 3, 4, 5, 6, 10, 11}) ? 1 : 0) +
                      ((ic inside {3, 4, 5, 7, 8}) ? 8 : 0);
            pc += len;
         end
         mem[pc] = ($urandom_range(99) < 20) ? {4'($urandom_range(12, 15)), 4'h0} : 8'h00;
         if ($urandom_range(99) < 30) err_m[$urandom_range(0, pc)] = 1'b1;
         exp_q.delete(); exp_req.delete();
         p = 64'd0;
         for (int n = 0; n < 300; n++) begin
            m = model(p);
            exp_q.push_back(m);
            for (int j = 0; j < m.nreq; j++) exp_req.push_back(p + 64'(j));
            if (m.stat != 2'd0) break;
            p = m.valp;
         end
         lat_pct = $urandom_range(0, 60);
         rdy_pct = $urandom_range(30, 100);
         do_reset();
         run_until_stop(6000);
         bad = 0;
         if (out_q.size() != exp_q.size()) bad++;
         else foreach (exp_q[i])
            if ({out_q[i].icode, out_q[i].ifun, out_q[i].ra, out_q[i].rb, out_q[i].valc, out_q[i].valp, out_q[i].stat} !==
                {exp_q[i].icode, exp_q[i].ifun, exp_q[i].ra, exp_q[i].rb, exp_q[i].valc, exp_q[i].valp, exp_q[i].stat})
               bad++;
         tests++;
         if (bad != 0) begin
            fails++;
            $display("FAIL random_fields: iter %0d got %0d outputs with %0d wrong, required %0d outputs matching the model",
                     it, out_q.size(), bad, exp_q.size());
         end
         bad = 0;
         if (req_q.size() != exp_req.size()) bad++;
         else foreach (exp_req[i]) if (req_q[i] !== exp_req[i]) bad++;
         tests++;
         if (bad != 0) begin
            fails++;
            $display("FAIL random_reqs: iter %0d got %0d requests with %0d wrong, required %0d",
                     it, req_q.size(), bad, exp_req.size());
         end
      end
   endtask

   initial begin
      lat_pct = 0;
      rdy_pct = 100;
      test_reset();
      test_irmovq();
      test_sequence();
      test_invalid();
      test_rerr();
      test_redirect();
      test_stall();
      test_timeout();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
